// File: rtl/regfile_wr_arbiter_pkg.sv
// Shared constants and types for the register-file write-port arbiter.
package regfile_wr_arbiter_pkg;

   // One base64 digit per register, eight registers.
   localparam int DW   = 6;
   localparam int AW   = 3;
   localparam int NREG = 2 ** AW;

   // Value swept into every register by the scrub sequencer.
   localparam logic [DW-1:0] SCRUB_VAL = '0;

   // Address of the final register touched by a sweep.
   localparam logic [AW-1:0] LAST_IDX = AW'(NREG - 1);

   typedef enum logic {
      IDLE  = 1'b0,
      SCRUB = 1'b1
   } state_t;

   typedef enum logic {
      ID_A = 1'b0,
      ID_B = 1'b1
   } req_id_t;

endpackage

// File: rtl/regfile_wr_arbiter_rr_arb2.sv
// Two-way round-robin picker; the LAST flop lives in the parent.
module rr_arb2
   import regfile_wr_arbiter_pkg::*;
(
   input  logic    elig_a_i,
   input  logic    elig_b_i,
   input  req_id_t last_i,
   output logic    gnt_a_o,
   output logic    gnt_b_o,
   output logic    any_o
);

   // A lone eligible requester always wins; on a tie the one not served last wins.
   always_comb begin
      gnt_a_o = elig_a_i & (~elig_b_i | (last_i == ID_B));
      gnt_b_o = elig_b_i & (~elig_a_i | (last_i == ID_A));
      any_o   = elig_a_i | elig_b_i;
   end

endmodule

// File: rtl/regfile_wr_arbiter.sv
// Owns the register-file write port: round-robin between requesters A and B,
// plus a scrub sequencer that sweeps SCRUB_VAL into every register.
module regfile_wr_arbiter
   import regfile_wr_arbiter_pkg::*;
(
   input  logic          clk_i,
   input  logic          clr_i,
   input  logic          req_a_i,
   input  logic [AW-1:0] addr_a_i,
   input  logic [DW-1:0] data_a_i,
   output logic          ack_a_o,
   input  logic          req_b_i,
   input  logic [AW-1:0] addr_b_i,
   input  logic [DW-1:0] data_b_i,
   output logic          ack_b_o,
   input  logic          scrub_req_i,
   output logic          wr_o,
   output logic [AW-1:0] wa_o,
   output logic [DW-1:0] ld_data_o,
   output logic          busy_o,
   output logic          scrub_done_o
);

   state_t        stateQ;
   req_id_t       lastQ;
   logic [AW-1:0] countQ;
   logic [AW-1:0] countD;
   logic          wrQ;
   logic [AW-1:0] waQ;
   logic [DW-1:0] ldDataQ;
   logic          ackAQ;
   logic          ackBQ;
   logic          busyQ;
   logic          scrubDoneQ;

   logic          eligA;
   logic          eligB;
   logic          gntA;
   logic          gntB;
   logic          anyGnt;

   // A requester already being acked this cycle must not be granted again.
   assign eligA  = req_a_i & ~ackAQ;
   assign eligB  = req_b_i & ~ackBQ;

   // Sweep index advances by one and wraps naturally after the last register.
   assign countD = countQ + 1'b1;

   rr_arb2 u_rr_arb2 (
      .elig_a_i (eligA),
      .elig_b_i (eligB),
      .last_i   (lastQ),
      .gnt_a_o  (gntA),
      .gnt_b_o  (gntB),
      .any_o    (anyGnt)
   );

   // Control FSM with registered write-port, handshake and status outputs.
   always_ff @(posedge clk_i or posedge clr_i) begin
      if (clr_i) begin
         stateQ     <= IDLE;
         lastQ      <= ID_B;
         countQ     <= '0;
         wrQ        <= 1'b0;
         waQ        <= '0;
         ldDataQ    <= '0;
         ackAQ      <= 1'b0;
         ackBQ      <= 1'b0;
         busyQ      <= 1'b0;
         scrubDoneQ <= 1'b0;
      end else begin
         case (stateQ)
            IDLE: begin
               scrubDoneQ <= 1'b0;
               if (scrub_req_i) begin
                  stateQ  <= SCRUB;
                  countQ  <= '0;
                  wrQ     <= 1'b1;
                  waQ     <= '0;
                  ldDataQ <= SCRUB_VAL;
                  ackAQ   <= 1'b0;
                  ackBQ   <= 1'b0;
                  busyQ   <= 1'b1;
               end else begin
                  wrQ   <= anyGnt;
                  ackAQ <= gntA;
                  ackBQ <= gntB;
                  busyQ <= 1'b0;
                  if (gntA) begin
                     waQ     <= addr_a_i;
                     ldDataQ <= data_a_i;
                     lastQ   <= ID_A;
                  end else if (gntB) begin
                     waQ     <= addr_b_i;
                     ldDataQ <= data_b_i;
                     lastQ   <= ID_B;
                  end
               end
            end
            SCRUB: begin
               ackAQ  <= 1'b0;
               ackBQ  <= 1'b0;
               countQ <= countD;
               if (countQ == LAST_IDX) begin
                  stateQ     <= IDLE;
                  wrQ        <= 1'b0;
                  busyQ      <= 1'b0;
                  scrubDoneQ <= 1'b1;
               end else begin
                  wrQ     <= 1'b1;
                  waQ     <= countD;
                  ldDataQ <= SCRUB_VAL;
                  busyQ   <= 1'b1;
               end
            end
            default: begin
               stateQ <= IDLE;
               wrQ    <= 1'b0;
               busyQ  <= 1'b0;
            end
         endcase
      end
   end

   assign wr_o         = wrQ;
   assign wa_o         = waQ;
   assign ld_data_o    = ldDataQ;
   assign ack_a_o      = ackAQ;
   assign ack_b_o      = ackBQ;
   assign busy_o       = busyQ;
   assign scrub_done_o = scrubDoneQ;

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Directed bench for regfile_wr_arbiter with a behavioural register file.
module tb_regfile_wr_arbiter;

   logic       clk;
   logic       clr;
   logic       reqA;
   logic [2:0] addrA;
   logic [5:0] dataA;
   logic       ackA;
   logic       reqB;
   logic [2:0] addrB;
   logic [5:0] dataB;
   logic       ackB;
   logic       scrubReq;
   logic       wr;
   logic [2:0] wa;
   logic [5:0] ldData;
   logic       busy;
   logic       scrubDone;

   logic [5:0] rf [8];

   int total;
   int bad;

   regfile_wr_arbiter dut (
      .clk_i        (clk),
      .clr_i        (clr),
      .req_a_i      (reqA),
      .addr_a_i     (addrA),
      .data_a_i     (dataA),
      .ack_a_o      (ackA),
      .req_b_i      (reqB),
      .addr_b_i     (addrB),
      .data_b_i     (dataB),
      .ack_b_o      (ackB),
      .scrub_req_i  (scrubReq),
      .wr_o         (wr),
      .wa_o         (wa),
      .ld_data_o    (ldData),
      .busy_o       (busy),
      .scrub_done_o (scrubDone)
   );

   // Free-running clock, 10 time units per period.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Register file behind the write port; it is never cleared.
   always @(posedge clk) begin
      if (wr) rf[wa] <= ldData;
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One complete write from requester A: request, expect ack, release.
   task automatic applyStimulus(input logic [2:0] a, input logic [5:0] d);
      reqA  = 1'b1;
      addrA = a;
      dataA = d;
      step();
      checkOutput("single_ack_a", 32'(ackA), 32'd1);
      reqA = 1'b0;
      step();
   endtask

   initial begin
      total    = 0;
      bad      = 0;
      clr      = 1'b1;
      reqA     = 1'b0;
      reqB     = 1'b0;
      addrA    = '0;
      addrB    = '0;
      dataA    = '0;
      dataB    = '0;
      scrubReq = 1'b0;

      // Reset held with random inputs.
      for (int i = 0; i < 3; i++) begin
         reqA     = 1'($urandom);
         reqB     = 1'($urandom);
         addrA    = 3'($urandom);
         addrB    = 3'($urandom);
         dataA    = 6'($urandom);
         dataB    = 6'($urandom);
         scrubReq = 1'($urandom);
         step();
      end
      checkOutput("rst_wr",    32'(wr),        32'd0);
      checkOutput("rst_wa",    32'(wa),        32'd0);
      checkOutput("rst_ld",    32'(ldData),    32'd0);
      checkOutput("rst_acka",  32'(ackA),      32'd0);
      checkOutput("rst_ackb",  32'(ackB),      32'd0);
      checkOutput("rst_busy",  32'(busy),      32'd0);
      checkOutput("rst_done",  32'(scrubDone), 32'd0);

      // First write after reset: A to register 5.
      reqA = 1'b0; reqB = 1'b0; scrubReq = 1'b0;
      clr  = 1'b0;
      reqA = 1'b1; addrA = 3'd5; dataA = 6'h2A;
      step();
      checkOutput("first_wr",   32'(wr),     32'd1);
      checkOutput("first_wa",   32'(wa),     32'd5);
      checkOutput("first_ld",   32'(ldData), 32'h2A);
      checkOutput("first_acka", 32'(ackA),   32'd1);
      checkOutput("first_ackb", 32'(ackB),   32'd0);
      reqA = 1'b0;
      step();
      checkOutput("first_acka_off", 32'(ackA),  32'd0);
      checkOutput("first_wr_off",   32'(wr),    32'd0);
      checkOutput("first_rf5",      32'(rf[5]), 32'h2A);

      // Fresh reset so A wins the first tie.
      clr = 1'b1;
      step();
      clr = 1'b0;
      reqA = 1'b1; addrA = 3'd1; dataA = 6'h11;
      reqB = 1'b1; addrB = 3'd2; dataB = 6'h22;
      step();
      checkOutput("tie_acka1", 32'(ackA),   32'd1);
      checkOutput("tie_ackb1", 32'(ackB),   32'd0);
      checkOutput("tie_wr1",   32'(wr),     32'd1);
      checkOutput("tie_wa1",   32'(wa),     32'd1);
      checkOutput("tie_ld1",   32'(ldData), 32'h11);
      reqA = 1'b0;
      step();
      checkOutput("tie_acka2", 32'(ackA),   32'd0);
      checkOutput("tie_ackb2", 32'(ackB),   32'd1);
      checkOutput("tie_wr2",   32'(wr),     32'd1);
      checkOutput("tie_wa2",   32'(wa),     32'd2);
      checkOutput("tie_ld2",   32'(ldData), 32'h22);
      reqB = 1'b0;
      step();
      checkOutput("tie_wr3",   32'(wr),    32'd0);
      checkOutput("tie_ackb3", 32'(ackB),  32'd0);
      checkOutput("tie_rf1",   32'(rf[1]), 32'h11);
      checkOutput("tie_rf2",   32'(rf[2]), 32'h22);

      // Continuous contention: LAST is B, so A leads and grants alternate.
      reqA = 1'b1; addrA = 3'd4; dataA = 6'h0A;
      reqB = 1'b1; addrB = 3'd6; dataB = 6'h0B;
      for (int i = 0; i < 10; i++) begin
         step();
         checkOutput("cont_acka", 32'(ackA), (i % 2 == 0) ? 32'd1 : 32'd0);
         checkOutput("cont_ackb", 32'(ackB), (i % 2 == 1) ? 32'd1 : 32'd0);
         checkOutput("cont_wr",   32'(wr),   32'd1);
      end
      reqA = 1'b0; reqB = 1'b0;
      step();
      checkOutput("cont_idle_wr", 32'(wr), 32'd0);

      // Make A the last served, then collide on register 3.
      applyStimulus(3'd6, 6'h06);
      reqA = 1'b1; addrA = 3'd3; dataA = 6'h01;
      reqB = 1'b1; addrB = 3'd3; dataB = 6'h3F;
      step();
      checkOutput("same_ackb", 32'(ackB),   32'd1);
      checkOutput("same_acka", 32'(ackA),   32'd0);
      checkOutput("same_ld1",  32'(ldData), 32'h3F);
      reqB = 1'b0;
      step();
      checkOutput("same_acka2", 32'(ackA),   32'd1);
      checkOutput("same_ld2",   32'(ldData), 32'h01);
      reqA = 1'b0;
      step();
      checkOutput("same_rf3", 32'(rf[3]), 32'h01);

      // Scrub with a pending A request.
      for (int r = 0; r < 8; r++) applyStimulus(3'(r), 6'h3F);
      checkOutput("preload_rf7", 32'(rf[7]), 32'h3F);
      scrubReq = 1'b1;
      reqA = 1'b1; addrA = 3'd0; dataA = 6'h15;
      step();
      scrubReq = 1'b0;
      for (int k = 0; k < 8; k++) begin
         checkOutput("scrub_wr",   32'(wr),     32'd1);
         checkOutput("scrub_wa",   32'(wa),     32'(k));
         checkOutput("scrub_ld",   32'(ldData), 32'd0);
         checkOutput("scrub_busy", 32'(busy),   32'd1);
         checkOutput("scrub_acka", 32'(ackA),   32'd0);
         step();
      end
      checkOutput("scrub_done",      32'(scrubDone), 32'd1);
      checkOutput("scrub_done_wr",   32'(wr),        32'd0);
      checkOutput("scrub_done_busy", 32'(busy),      32'd0);
      checkOutput("scrub_done_acka", 32'(ackA),      32'd0);
      step();
      checkOutput("post_scrub_done", 32'(scrubDone), 32'd0);
      checkOutput("post_scrub_wr",   32'(wr),        32'd1);
      checkOutput("post_scrub_wa",   32'(wa),        32'd0);
      checkOutput("post_scrub_ld",   32'(ldData),    32'h15);
      checkOutput("post_scrub_acka", 32'(ackA),      32'd1);
      reqA = 1'b0;
      step();
      checkOutput("post_scrub_rf0", 32'(rf[0]), 32'h15);
      for (int r = 1; r < 8; r++) checkOutput("post_scrub_rf", 32'(rf[r]), 32'd0);

      // Reset while the sweep is presenting register 4.
      for (int r = 0; r < 8; r++) applyStimulus(3'(r), 6'h3F);
      scrubReq = 1'b1;
      step();
      scrubReq = 1'b0;
      for (int k = 0; k < 4; k++) step();
      checkOutput("mid_wa4", 32'(wa), 32'd4);
      clr = 1'b1;
      #1;
      checkOutput("mid_clr_wr",   32'(wr),   32'd0);
      checkOutput("mid_clr_busy", 32'(busy), 32'd0);
      step();
      clr = 1'b0;
      step();
      checkOutput("mid_rel_wr",   32'(wr),        32'd0);
      checkOutput("mid_rel_busy", 32'(busy),      32'd0);
      checkOutput("mid_rel_done", 32'(scrubDone), 32'd0);
      for (int r = 0; r < 4; r++) checkOutput("mid_rf_low",  32'(rf[r]), 32'd0);
      for (int r = 4; r < 8; r++) checkOutput("mid_rf_high", 32'(rf[r]), 32'h3F);
      applyStimulus(3'd7, 6'h2A);
      checkOutput("mid_idle_rf7", 32'(rf[7]), 32'h2A);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
